// File: rtl/mips_run_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mips_run_ctrl
//
// Run controller for the pipelined MIPS32 core. It streams a program into
// instruction memory, releases the core for a watchdog-bounded run, and after
// HALT walks the register file against an expected-value table.
//
// Ports
//   clk1         : sole clock, rising edge
//   rst_n        : asynchronous active-low reset (aborts to IDLE)
//   start        : begin a load (IDLE or DONE only)
//   ld_valid/ld_data/ld_last/ld_ready : program word stream handshake
//   imem_we/imem_addr/imem_wdata      : imem write port (combinational on accept)
//   cpu_hold     : core frozen whenever not in RUN
//   cpu_init     : one-cycle pulse in the first RUN cycle (clears PC/flags)
//   cpu_halted   : core HALTED flag
//   rf_raddr/rf_rdata/exp_rdata       : register walk and expected table
//   done/pass/timeout/fail_idx/cycles/words_loaded : registered run status
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int CHECK_N = 6,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              cpu_init,
    input  logic              cpu_halted,
    output logic [4:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    input  logic [31:0]       exp_rdata,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [4:0]        fail_idx,
    output logic [CNT_W-1:0]  cycles,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CNT_W-1:0]  CYC_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]        IDX_LAST  = 5'(CHECK_N - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};

    logic [2:0]        state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W:0]   words_r;
    logic [CNT_W-1:0]  cycles_r;
    logic [4:0]        idx_r;
    logic              init_r;
    logic              done_r;
    logic              pass_r;
    logic              timeout_r;
    logic [4:0]        fail_idx_r;

    logic              accept_s;
    logic              load_end_s;
    logic              match_s;

    // Stream handshake decode: accept, implicit/explicit end of load, compare.
    always_comb begin
        accept_s   = 1'b0;
        load_end_s = 1'b0;
        match_s    = (rf_rdata == exp_rdata);
        if (state_r == ST_LOAD) begin
            accept_s   = ld_valid;
            // Last imem slot truncates the stream exactly like ld_last.
            load_end_s = ld_valid & (ld_last | (ptr_r == PTR_LAST));
        end else begin
            accept_s   = 1'b0;
            load_end_s = 1'b0;
        end
    end

    assign ld_ready     = (state_r == ST_LOAD);
    assign imem_we      = accept_s;
    assign imem_addr    = ptr_r;
    assign imem_wdata   = accept_s ? ld_data : 32'd0;
    assign cpu_hold     = (state_r != ST_RUN);
    assign cpu_init     = init_r;
    assign rf_raddr     = (state_r == ST_CHECK) ? idx_r : 5'd0;
    assign done         = done_r;
    assign pass         = pass_r;
    assign timeout      = timeout_r;
    assign fail_idx     = fail_idx_r;
    assign cycles       = cycles_r;
    assign words_loaded = words_r;

    // Controller state machine and registered run status.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {ADDR_W{1'b0}};
            words_r    <= {(ADDR_W+1){1'b0}};
            cycles_r   <= {CNT_W{1'b0}};
            idx_r      <= 5'd0;
            init_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            timeout_r  <= 1'b0;
            fail_idx_r <= 5'd0;
        end else begin
            init_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // A restart clears every status field on the same edge.
                        state_r    <= ST_LOAD;
                        ptr_r      <= {ADDR_W{1'b0}};
                        words_r    <= {(ADDR_W+1){1'b0}};
                        cycles_r   <= {CNT_W{1'b0}};
                        idx_r      <= 5'd0;
                        done_r     <= 1'b0;
                        pass_r     <= 1'b0;
                        timeout_r  <= 1'b0;
                        fail_idx_r <= 5'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        ptr_r   <= ptr_r + ADDR_W'(1'b1);
                        words_r <= words_r + (ADDR_W+1)'(1'b1);
                    end else begin
                        ptr_r   <= ptr_r;
                        words_r <= words_r;
                    end
                    if (load_end_s) begin
                        state_r <= ST_RUN;
                        init_r  <= 1'b1;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    cycles_r <= cycles_r + CNT_W'(1'b1);
                    // Halt is tested first so it wins over a coincident timeout.
                    if (cpu_halted) begin
                        state_r <= ST_CHECK;
                        idx_r   <= 5'd0;
                    end else if (cycles_r == CYC_LIMIT) begin
                        state_r   <= ST_DONE;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                        pass_r    <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_CHECK: begin
                    if (!match_s) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        pass_r     <= 1'b0;
                        fail_idx_r <= idx_r;
                    end else if (idx_r == IDX_LAST) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                    end else begin
                        idx_r <= idx_r + 5'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mips_run_ctrl
//
// Directed bench for mips_run_ctrl. The main instance (ADDR_W=10, TIMEOUT=64)
// covers load, pass, mismatch and watchdog runs against a small core and
// register-file model; a second instance (ADDR_W=3) covers stream truncation
// and restart from DONE.
// -----------------------------------------------------------------------------
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Main instance signals
    logic        start, ld_valid, ld_last, ld_ready, imem_we;
    logic [31:0] ld_data, imem_wdata, rf_rdata, exp_rdata;
    logic [9:0]  imem_addr;
    logic        cpu_hold, cpu_init, cpu_halted;
    logic [4:0]  rf_raddr, fail_idx;
    logic        done, pass, timeout;
    logic [15:0] cycles;
    logic [10:0] words_loaded;

    // Truncation instance signals
    logic        t_start, t_ld_valid, t_ld_last, t_ld_ready, t_imem_we;
    logic [31:0] t_ld_data, t_imem_wdata, t_rf_rdata, t_exp_rdata;
    logic [2:0]  t_imem_addr;
    logic        t_cpu_hold, t_cpu_init, t_cpu_halted;
    logic [4:0]  t_rf_raddr, t_fail_idx;
    logic        t_done, t_pass, t_timeout;
    logic [15:0] t_cycles;
    logic [3:0]  t_words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prog    [9];
    logic [31:0] regs    [32];
    logic [31:0] exp_tab [32];
    int          halt_at = 0;
    int          run_cyc;

    mips_run_ctrl #(.ADDR_W(10), .CHECK_N(6), .TIMEOUT(64), .CNT_W(16)) u_dut (
        .clk1(clk), .rst_n(rst_n), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .cpu_init(cpu_init), .cpu_halted(cpu_halted),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .exp_rdata(exp_rdata),
        .done(done), .pass(pass), .timeout(timeout), .fail_idx(fail_idx),
        .cycles(cycles), .words_loaded(words_loaded)
    );

    mips_run_ctrl #(.ADDR_W(3), .CHECK_N(6), .TIMEOUT(64), .CNT_W(16)) u_trunc (
        .clk1(clk), .rst_n(rst_n), .start(t_start),
        .ld_valid(t_ld_valid), .ld_data(t_ld_data), .ld_last(t_ld_last), .ld_ready(t_ld_ready),
        .imem_we(t_imem_we), .imem_addr(t_imem_addr), .imem_wdata(t_imem_wdata),
        .cpu_hold(t_cpu_hold), .cpu_init(t_cpu_init), .cpu_halted(t_cpu_halted),
        .rf_raddr(t_rf_raddr), .rf_rdata(t_rf_rdata), .exp_rdata(t_exp_rdata),
        .done(t_done), .pass(t_pass), .timeout(t_timeout), .fail_idx(t_fail_idx),
        .cycles(t_cycles), .words_loaded(t_words_loaded)
    );

    // Core model: counts RUN cycles (1-based) and raises HALTED in cycle halt_at.
    always @(posedge clk) begin
        if (cpu_hold) run_cyc <= 1;
        else          run_cyc <= run_cyc + 1;
    end
    assign cpu_halted = (halt_at != 0) && !cpu_hold && (run_cyc == halt_at);

    // Register file and expected table, both combinational on rf_raddr.
    assign rf_rdata  = regs[rf_raddr];
    assign exp_rdata = exp_tab[rf_raddr];

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Nine words with bubbles in slots 2 and 6, ld_last on the ninth word.
    task automatic load_prog();
        int wi = 0;
        for (int s = 0; s < 11; s++) begin
            if (s == 2 || s == 6) begin
                ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'hdeadbeef;
                #1;
                n_checks++;
                if (imem_we !== 1'b0) $display("FAIL load_bubble slot %0d imem_we=%b want 0", s, imem_we);
                else n_pass++;
            end else begin
                ld_valid = 1'b1; ld_last = (wi == 8); ld_data = prog[wi];
                #1;
                n_checks++;
                if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'(wi), prog[wi]})
                    $display("FAIL load_write word %0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                             wi, imem_we, imem_addr, imem_wdata, wi, prog[wi]);
                else n_pass++;
                wi++;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // Called at the negedge of RUN cycle 1; returns at the first DONE cycle.
    task automatic run_to_done(output int run_n, output int chk_n,
                               output int init_n, output bit init_first);
        run_n = 0; chk_n = 0; init_n = 0; init_first = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (done === 1'b1) break;
            if (cpu_init === 1'b1) begin
                init_n++;
                if (!cpu_hold && run_n == 0) init_first = 1'b1;
            end
            if (cpu_hold === 1'b0) run_n++;
            else if (run_n > 0) chk_n++;
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL run_done_wait done=%b want 1 within budget", done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (cpu_hold !== 1'b1) $display("FAIL reset_hold got %b want 1", cpu_hold);
        else n_pass++;
        n_checks++;
        if ({ld_ready, imem_we, cpu_init, done, pass, timeout, fail_idx, cycles, words_loaded, rf_raddr} !== 41'd0)
            $display("FAIL reset_outputs got rdy=%b we=%b init=%b done=%b pass=%b to=%b fidx=%0d cyc=%0d words=%0d raddr=%0d want all 0",
                     ld_ready, imem_we, cpu_init, done, pass, timeout, fail_idx, cycles, words_loaded, rf_raddr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (ld_ready !== 1'b0) $display("FAIL idle_ready got %b want 0", ld_ready);
        else n_pass++;
        // Reset asserted in the middle of a load aborts to IDLE at once.
        do_start();
        ld_valid = 1'b1; ld_last = 1'b0; ld_data = prog[0];
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (words_loaded !== 11'd2) $display("FAIL midload_words got %0d want 2", words_loaded);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cpu_hold, ld_ready, imem_we, words_loaded, cycles, done} !== {1'b1, 1'b0, 1'b0, 11'd0, 16'd0, 1'b0})
            $display("FAIL midload_reset got hold=%b rdy=%b we=%b words=%0d cyc=%0d done=%b want 1 0 0 0 0 0",
                     cpu_hold, ld_ready, imem_we, words_loaded, cycles, done);
        else n_pass++;
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (ld_ready !== 1'b0) $display("FAIL reset_next_ready got %b want 0", ld_ready);
        else n_pass++;
    endtask

    int  r_run, r_chk, r_init;
    bit  r_first;

    task automatic test_load();
        halt_at = 20;
        @(negedge clk);
        do_start();
        load_prog();
        run_to_done(r_run, r_chk, r_init, r_first);
        n_checks++;
        if (words_loaded !== 11'd9) $display("FAIL load_words got %0d want 9", words_loaded);
        else n_pass++;
        n_checks++;
        if (r_init != 1 || !r_first) $display("FAIL load_init_pulse got count=%0d first=%0d want 1 1", r_init, r_first);
        else n_pass++;
    endtask

    task automatic test_pass();
        n_checks++;
        if (r_run != 20 || cycles !== 16'd20) $display("FAIL pass_cycles got run=%0d cycles=%0d want 20 20", r_run, cycles);
        else n_pass++;
        n_checks++;
        if (r_chk != 6) $display("FAIL pass_check_len got %0d want 6", r_chk);
        else n_pass++;
        n_checks++;
        if ({done, pass, timeout, fail_idx} !== {1'b1, 1'b1, 1'b0, 5'd0})
            $display("FAIL pass_status got done=%b pass=%b to=%b fidx=%0d want 1 1 0 0", done, pass, timeout, fail_idx);
        else n_pass++;
        n_checks++;
        if ({cpu_hold, rf_raddr} !== {1'b1, 5'd0}) $display("FAIL pass_idle_pins got hold=%b raddr=%0d want 1 0", cpu_hold, rf_raddr);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        exp_tab[3] = 32'd26;
        do_start();
        #1;
        n_checks++;
        if ({done, pass, timeout, fail_idx, cycles, words_loaded} !== {3'b000, 5'd0, 16'd0, 11'd0})
            $display("FAIL restart_clear got done=%b pass=%b to=%b fidx=%0d cyc=%0d words=%0d want all 0",
                     done, pass, timeout, fail_idx, cycles, words_loaded);
        else n_pass++;
        load_prog();
        run_to_done(r_run, r_chk, r_init, r_first);
        n_checks++;
        if ({pass, timeout, fail_idx} !== {1'b0, 1'b0, 5'd3}) $display("FAIL mismatch_status got pass=%b to=%b fidx=%0d want 0 0 3", pass, timeout, fail_idx);
        else n_pass++;
        n_checks++;
        if (r_chk != 4) $display("FAIL mismatch_check_len got %0d want 4", r_chk);
        else n_pass++;
        n_checks++;
        if (cycles !== 16'd20) $display("FAIL mismatch_cycles got %0d want 20", cycles);
        else n_pass++;
        exp_tab[3] = 32'd25;
    endtask

    task automatic test_watchdog();
        halt_at = 0;
        do_start();
        load_prog();
        run_to_done(r_run, r_chk, r_init, r_first);
        n_checks++;
        if (r_run != 64 || cycles !== 16'd64) $display("FAIL wd_cycles got run=%0d cycles=%0d want 64 64", r_run, cycles);
        else n_pass++;
        n_checks++;
        if ({timeout, pass} !== 2'b10 || r_chk != 0) $display("FAIL wd_status got to=%b pass=%b chk=%0d want 1 0 0", timeout, pass, r_chk);
        else n_pass++;
        // Halt in the very cycle the watchdog would fire: halt wins.
        halt_at = 64;
        do_start();
        load_prog();
        run_to_done(r_run, r_chk, r_init, r_first);
        n_checks++;
        if (r_run != 64 || cycles !== 16'd64) $display("FAIL wd_edge_cycles got run=%0d cycles=%0d want 64 64", r_run, cycles);
        else n_pass++;
        n_checks++;
        if ({timeout, pass} !== 2'b01 || r_chk != 6) $display("FAIL wd_edge_status got to=%b pass=%b chk=%0d want 0 1 6", timeout, pass, r_chk);
        else n_pass++;
    endtask

    task automatic test_truncation();
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        for (int s = 0; s < 10; s++) begin
            t_ld_valid = 1'b1; t_ld_last = 1'b0; t_ld_data = 32'h1000_0000 + 32'(s);
            #1;
            n_checks++;
            if (s < 8) begin
                if ({t_ld_ready, t_imem_we, t_imem_addr, t_imem_wdata} !== {1'b1, 1'b1, 3'(s), 32'h1000_0000 + 32'(s)})
                    $display("FAIL trunc_write slot %0d got rdy=%b we=%b addr=%0d data=%h want 1 1 %0d %h",
                             s, t_ld_ready, t_imem_we, t_imem_addr, t_imem_wdata, s, 32'h1000_0000 + 32'(s));
                else n_pass++;
            end else begin
                if ({t_ld_ready, t_imem_we} !== 2'b00)
                    $display("FAIL trunc_refuse slot %0d got rdy=%b we=%b want 0 0", s, t_ld_ready, t_imem_we);
                else n_pass++;
            end
            @(negedge clk);
        end
        t_ld_valid = 1'b0;
        #1;
        n_checks++;
        if ({t_words_loaded, t_ld_ready, t_cpu_hold} !== {4'd8, 1'b0, 1'b0})
            $display("FAIL trunc_run got words=%0d rdy=%b hold=%b want 8 0 0", t_words_loaded, t_ld_ready, t_cpu_hold);
        else n_pass++;
        for (int i = 0; i < 200; i++) begin
            if (t_done === 1'b1) break;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if ({t_done, t_timeout, t_cycles} !== {1'b1, 1'b1, 16'd64})
            $display("FAIL trunc_done got done=%b to=%b cyc=%0d want 1 1 64", t_done, t_timeout, t_cycles);
        else n_pass++;
    endtask

    task automatic test_restart();
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        #1;
        n_checks++;
        if ({t_done, t_pass, t_timeout, t_cycles, t_words_loaded, t_ld_ready} !== {3'b000, 16'd0, 4'd0, 1'b1})
            $display("FAIL restart_trunc got done=%b pass=%b to=%b cyc=%0d words=%0d rdy=%b want 0 0 0 0 0 1",
                     t_done, t_pass, t_timeout, t_cycles, t_words_loaded, t_ld_ready);
        else n_pass++;
    endtask

    initial begin
        prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
        prog[3] = 32'h0cc77800; prog[4] = 32'h0cc77800; prog[5] = 32'h00222000;
        prog[6] = 32'h0cc77800; prog[7] = 32'h00832800; prog[8] = 32'hfc000000;
        for (int i = 0; i < 32; i++) begin
            regs[i]    = 32'd0;
            exp_tab[i] = 32'd0;
        end
        regs[1] = 32'd10; regs[2] = 32'd20; regs[3] = 32'd25; regs[4] = 32'd30; regs[5] = 32'd55;
        exp_tab[1] = 32'd10; exp_tab[2] = 32'd20; exp_tab[3] = 32'd25; exp_tab[4] = 32'd30; exp_tab[5] = 32'd55;
        start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'd0;
        t_start = 1'b0; t_ld_valid = 1'b0; t_ld_last = 1'b0; t_ld_data = 32'd0;
        t_cpu_halted = 1'b0; t_rf_rdata = 32'd0; t_exp_rdata = 32'd0;

        test_reset();
        test_load();
        test_pass();
        test_mismatch();
        test_watchdog();
        test_truncation();
        test_restart();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
